// File: rtl/adder_control_unit.sv
// Sequencing FSM for the 32-bit adder datapath: conditions the Enter button
// and steps operand loading, the ready wait and result display pages.
module adder_control_unit #(
  parameter int NBYTES      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RDY_TIMEOUT = 16,
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1,
  localparam int TW = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enter_btn,
  input  logic          clear,
  input  logic          inputdata_ready,
  output logic          loaddata,
  output logic          enter_pulse,
  output logic [IW-1:0] byte_idx,
  output logic [2:0]    state_code,
  output logic          error
);

  localparam logic [2:0] S_LOADA = 3'd0;
  localparam logic [2:0] S_LOADB = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SHOW  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  localparam logic [TW-1:0] LAST_TMO = TW'(RDY_TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] ens_q;
  logic [SYNC_STAGES-1:0] clrs_q;
  logic                   enter_prev_q;
  logic                   pulse_q, pulse_d;
  logic [2:0]             state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [TW-1:0]          tmo_q, tmo_d;

  logic enter_s;
  logic clr_s;
  logic enter_edge;
  logic fwd_state;

  assign enter_s    = ens_q[SYNC_STAGES-1];
  assign clr_s      = clrs_q[SYNC_STAGES-1];
  assign enter_edge = enter_s & ~enter_prev_q;
  assign fwd_state  = (state_q == S_LOADA) ||
                      (state_q == S_LOADB) ||
                      (state_q == S_SHOW);

  // Edges in WAIT/ERR are swallowed; clear always wins over a pulse.
  assign pulse_d = enter_edge & fwd_state & ~clr_s;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    if (clr_s) begin
      state_d = S_LOADA;
      idx_d   = '0;
      tmo_d   = '0;
    end else begin
      unique case (state_q)
        S_LOADA: if (pulse_q) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_LOADB;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        S_LOADB: if (pulse_q) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_WAIT;
            idx_d   = '0;
            tmo_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        S_WAIT: begin
          tmo_d = tmo_q + TW'(1);
          if (inputdata_ready) begin
            state_d = S_SHOW;
            idx_d   = '0;
          end else if (tmo_q == LAST_TMO) begin
            state_d = S_ERR;
          end
        end
        S_SHOW: if (pulse_q) begin
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        end
        S_ERR: if (enter_edge) begin
          state_d = S_LOADA;
          idx_d   = '0;
        end
        default: begin
          state_d = S_LOADA;
          idx_d   = '0;
          tmo_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ens_q        <= '0;
      clrs_q       <= '0;
      enter_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
      state_q      <= S_LOADA;
      idx_q        <= '0;
      tmo_q        <= '0;
    end else begin
      ens_q        <= {ens_q[SYNC_STAGES-2:0], enter_btn};
      clrs_q       <= {clrs_q[SYNC_STAGES-2:0], clear};
      enter_prev_q <= enter_s;
      pulse_q      <= pulse_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
    end
  end

  assign loaddata    = (state_q == S_LOADA) || (state_q == S_LOADB);
  assign error       = (state_q == S_ERR);
  assign state_code  = state_q;
  assign byte_idx    = idx_q;
  assign enter_pulse = pulse_q;

endmodule

// File: tb/tb_adder_control_unit.sv
// Randomised scoreboard bench for adder_control_unit: a press-level model
// predicts every enter_pulse and the FSM view seen alongside it.
module tb_adder_control_unit;

  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter_btn;
  logic       clear;
  logic       inputdata_ready;
  logic       loaddata;
  logic       enter_pulse;
  logic [1:0] byte_idx;
  logic [2:0] state_code;
  logic       error;

  adder_control_unit dut (
    .clk            (clk),
    .reset          (reset),
    .enter_btn      (enter_btn),
    .clear          (clear),
    .inputdata_ready(inputdata_ready),
    .loaddata       (loaddata),
    .enter_pulse    (enter_pulse),
    .byte_idx       (byte_idx),
    .state_code     (state_code),
    .error          (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int idx;
    int ld;
  } exp_t;

  exp_t exq[$];
  int   checks = 0;
  int   errors = 0;
  int   ph = 0;
  int   idx = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Press-level model: phases 0 A, 1 B, 2 wait, 3 show, 4 error.
  function automatic void m_press();
    exp_t e;
    if (ph == 0 || ph == 1 || ph == 3) begin
      e.ph  = ph;
      e.idx = idx;
      e.ld  = (ph < 2) ? 1 : 0;
      exq.push_back(e);
      idx++;
      if (idx == NB) begin
        idx = 0;
        if (ph < 2) ph++;
      end
    end else if (ph == 4) begin
      ph  = 0;
      idx = 0;
    end
  endfunction

  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_pulse <= 1'b0;
    end else begin
      if (enter_pulse) begin
        chk("pulse_width", int'(prev_pulse), 0);
        if (exq.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = exq.pop_front();
          chk("pulse_state", int'(state_code), e.ph);
          chk("pulse_idx", int'(byte_idx), e.idx);
          chk("pulse_loaddata", int'(loaddata), e.ld);
        end
      end
      prev_pulse <= enter_pulse;
    end
  end

  task automatic press(input int hold, input int rel);
    m_press();
    @(negedge clk);
    enter_btn = 1'b1;
    repeat (hold) @(negedge clk);
    enter_btn = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic rpress();
    press($urandom_range(1, 6), $urandom_range(3, 6));
  endtask

  task automatic chk_view(input string name, input int st, input int ix);
    chk({name, "_state"}, int'(state_code), st);
    chk({name, "_idx"}, int'(byte_idx), ix);
  endtask

  // Clear with a coinciding press, then a press while clear is held.
  task automatic do_clear();
    @(negedge clk);
    clear     = 1'b1;
    enter_btn = 1'b1;
    repeat (4) @(negedge clk);
    enter_btn = 1'b0;
    repeat (3) @(negedge clk);
    enter_btn = 1'b1;
    repeat (3) @(negedge clk);
    enter_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk_view("clear_held", 0, 0);
    clear = 1'b0;
    repeat (4) @(negedge clk);
    chk_view("clear_done", 0, 0);
    ph  = 0;
    idx = 0;
  endtask

  // Load 8 bytes; the last press is tracked until WAIT is entered.
  task automatic load_and_enter_wait();
    int k;
    for (int i = 0; i < 2 * NB - 1; i++) rpress();
    chk_view("before_last_b", 1, NB - 1);
    m_press();
    @(negedge clk);
    enter_btn = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (state_code == 3'd2) break;
    end
    chk("wait_entry_bound", k < 20 ? 1 : 0, 1);
    chk("wait_loaddata", int'(loaddata), 0);
    enter_btn = 1'b0;
  endtask

  // mode 0: ready after d cycles, then clear; 1: timeout; 2: ready then reset.
  task automatic round(input int mode, input int d);
    int n;
    load_and_enter_wait();
    if (mode == 1) begin
      for (int k = 1; k <= 16; k++) begin
        @(posedge clk);
        #1;
        if (k == 2) enter_btn = 1'b1;
        if (k == 6) enter_btn = 1'b0;
        if (k == 15) chk("pre_timeout_state", int'(state_code), 2);
        if (k == 16) begin
          chk("timeout_state", int'(state_code), 4);
          chk("timeout_error", int'(error), 1);
        end
      end
      ph = 4;
      rpress();
      chk("err_exit_state", int'(state_code), 0);
      chk("err_exit_error", int'(error), 0);
      chk("err_exit_ld", int'(loaddata), 1);
    end else begin
      repeat (d) begin
        @(posedge clk);
        #1;
      end
      inputdata_ready = 1'b1;
      @(posedge clk);
      #1;
      inputdata_ready = 1'b0;
      chk_view("show_entry", 3, 0);
      chk("show_loaddata", int'(loaddata), 0);
      ph  = 3;
      idx = 0;
      n = (mode == 2) ? 2 : $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        inputdata_ready = 1'($urandom_range(0, 1));
        rpress();
      end
      inputdata_ready = 1'b0;
      chk_view("show_end", 3, idx);
      if (mode == 0) begin
        do_clear();
      end else begin
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_state", int'(state_code), 0);
        chk("async_rst_idx", int'(byte_idx), 0);
        chk("async_rst_ld", int'(loaddata), 1);
        chk("async_rst_pulse", int'(enter_pulse), 0);
        @(negedge clk);
        reset = 1'b0;
        ph  = 0;
        idx = 0;
      end
    end
  endtask

  initial begin
    int lat;
    reset           = 1'b1;
    enter_btn       = 1'b0;
    clear           = 1'b0;
    inputdata_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_view("reset", 0, 0);
    chk("reset_ld", int'(loaddata), 1);
    chk("reset_pulse", int'(enter_pulse), 0);
    chk("reset_error", int'(error), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) rpress();
    chk_view("five_loads", 1, 1);
    do_clear();

    m_press();
    @(negedge clk);
    enter_btn = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (enter_pulse) begin
        lat = k;
        break;
      end
    end
    chk("pulse_latency", lat, 3);
    repeat (100) @(negedge clk);
    enter_btn = 1'b0;
    repeat (5) @(negedge clk);
    chk_view("after_hold", 0, 1);
    do_clear();

    round(0, 3);
    round(0, 15);
    round(1, 0);
    for (int r = 0; r < 4; r++) begin
      if ($urandom_range(0, 2) == 0) round(1, 0);
      else round(0, $urandom_range(0, 15));
    end
    round(2, $urandom_range(0, 15));

    repeat (5) @(negedge clk);
    chk("queue_empty", exq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
